// File: rtl/voice_action_ctrl_if.sv
// Sample/control bundle between the volume averager and the game logic.
// The averager side (master) supplies volume samples and enable. The
// controller side (slave) returns run level, speed, jump events and debug state.
interface voice_action_ctrl_if;
  logic        enable;
  logic        vol_valid;
  logic [7:0]  vol;
  logic        run;
  logic [15:0] run_speed;
  logic        jump;
  logic [15:0] jump_height;
  logic [1:0]  jstate;

  modport master (
    output enable, vol_valid, vol,
    input  run, run_speed, jump, jump_height, jstate
  );

  modport slave (
    input  enable, vol_valid, vol,
    output run, run_speed, jump, jump_height, jstate
  );
endinterface

// File: rtl/voice_action_ctrl.sv
// voice_action_ctrl: turns averaged microphone volume samples into game
// control. Run is a hysteretic level with a 2/3/4 speed. Jump is a one-cycle
// pulse whose height is derived from the burst peak.
//
// Optional build macro SPEED_RAMP_EN: when defined, speed moves at most one
// step per valid sample toward its target while running. When undefined,
// speed loads the target directly.
//
// Jump FSM states:
//   state  | meaning
//   J_IDLE | waiting for a sample at or above JUMP_TH
//   J_RISE | inside a burst, tracking peak and burst length
//   J_COOL | jump just fired, ignoring COOLDOWN valid samples
//   (3)    | unused, recovers to J_IDLE
module voice_action_ctrl #(
  parameter logic [7:0]  RUN_ON       = 8'd30,
  parameter logic [7:0]  RUN_OFF      = 8'd25,
  parameter logic [7:0]  SPD3_TH      = 8'd45,
  parameter logic [7:0]  SPD4_TH      = 8'd60,
  parameter logic [7:0]  JUMP_TH      = 8'd80,
  parameter int unsigned MAX_RISE     = 6,
  parameter int unsigned COOLDOWN     = 4,
  parameter logic [15:0] JUMP_BASE    = 16'd8,
  parameter int unsigned HEIGHT_SHIFT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  voice_action_ctrl_if.slave bus
);

  localparam int unsigned RISE_W = $clog2(MAX_RISE + 1);
  localparam int unsigned COOL_W = $clog2(COOLDOWN + 1);
  localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(MAX_RISE);
  localparam logic [RISE_W-1:0] RISE_ONE  = RISE_W'(1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN);
  localparam logic [15:0] SPEED_MIN = 16'd2;
  localparam logic [15:0] SPEED_MID = 16'd3;
  localparam logic [15:0] SPEED_MAX = 16'd4;

  typedef enum logic [1:0] {
    J_IDLE = 2'd0,
    J_RISE = 2'd1,
    J_COOL = 2'd2
  } jstate_t;

  jstate_t           state_q, state_d;
  logic [7:0]        peak_q, peak_d;
  logic [RISE_W-1:0] rise_q, rise_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic              run_q, run_d;
  logic [15:0]       speed_q, speed_d;
  logic              jump_q, jump_d;
  logic [15:0]       height_q, height_d;

  logic [15:0]       speed_target;
  logic              vol_above_jump;
  logic [7:0]        peak_max;
  logic [RISE_W-1:0] rise_inc;
  logic [COOL_W-1:0] cool_inc;
  logic              fire;
  logic [7:0]        fire_peak;

  // Height excess is computed in 8 bits: peak >= JUMP_TH whenever a jump
  // fires, so the subtraction cannot wrap, even at peak = 255.
  function automatic logic [15:0] height_of(input logic [7:0] pk);
    logic [7:0] excess;
    excess = (pk - JUMP_TH) >> HEIGHT_SHIFT;
    return JUMP_BASE + {8'd0, excess};
  endfunction

  // Speed the current sample asks for, independent of run state.
  always_comb begin
    speed_target = SPEED_MIN;
    if (bus.vol >= SPD4_TH) begin
      speed_target = SPEED_MAX;
    end else if (bus.vol >= SPD3_TH) begin
      speed_target = SPEED_MID;
    end
  end

  // Run hysteresis and speed tracking, advanced only by valid samples.
  always_comb begin
    run_d   = run_q;
    speed_d = speed_q;
    if (!bus.enable) begin
      run_d   = 1'b0;
      speed_d = SPEED_MIN;
    end else if (bus.vol_valid) begin
      if (!run_q && (bus.vol >= RUN_ON)) begin
        run_d = 1'b1;
      end else if (run_q && (bus.vol < RUN_OFF)) begin
        run_d = 1'b0;
      end

      if (!run_d) begin
        speed_d = SPEED_MIN;
      end else begin
`ifdef SPEED_RAMP_EN
        // While stopped, speed already sits at 2, so a rising run ramps from 2.
        if (speed_target > speed_q) begin
          speed_d = speed_q + 16'd1;
        end else if (speed_target < speed_q) begin
          speed_d = speed_q - 16'd1;
        end
`else
        speed_d = speed_target;
`endif
      end
    end
  end

  // Jump FSM next state: burst tracking, fire decision and cooldown.
  always_comb begin
    state_d        = state_q;
    peak_d         = peak_q;
    rise_d         = rise_q;
    cool_d         = cool_q;
    jump_d         = 1'b0;
    height_d       = height_q;
    fire           = 1'b0;
    fire_peak      = peak_q;
    vol_above_jump = (bus.vol >= JUMP_TH);
    peak_max       = (bus.vol > peak_q) ? bus.vol : peak_q;
    rise_inc       = rise_q + 1'b1;
    cool_inc       = cool_q + 1'b1;

    if (!bus.enable) begin
      // A burst that is cut off by enable is dropped without a pulse.
      state_d = J_IDLE;
      peak_d  = 8'd0;
      rise_d  = '0;
      cool_d  = '0;
    end else if (bus.vol_valid) begin
      case (state_q)
        J_IDLE: begin
          if (vol_above_jump) begin
            state_d = J_RISE;
            peak_d  = bus.vol;
            rise_d  = RISE_ONE;
          end
        end
        J_RISE: begin
          if (vol_above_jump) begin
            peak_d = peak_max;
            rise_d = rise_inc;
            if (rise_inc == RISE_LAST) begin
              // Burst too long: force the jump out, peak includes this sample.
              fire      = 1'b1;
              fire_peak = peak_max;
            end
          end else begin
            fire      = 1'b1;
            fire_peak = peak_q;
          end
        end
        J_COOL: begin
          // The sample that ends cooldown is consumed here and never starts a burst.
          if (cool_inc == COOL_LAST) begin
            state_d = J_IDLE;
            cool_d  = '0;
          end else begin
            cool_d = cool_inc;
          end
        end
        default: begin
          state_d = J_IDLE;
          peak_d  = 8'd0;
          rise_d  = '0;
          cool_d  = '0;
        end
      endcase

      if (fire) begin
        jump_d   = 1'b1;
        height_d = height_of(fire_peak);
        state_d  = J_COOL;
        cool_d   = '0;
        peak_d   = 8'd0;
        rise_d   = '0;
      end
    end
  end

  // Register all state and outputs; reset wins over enable and samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= J_IDLE;
      peak_q   <= 8'd0;
      rise_q   <= '0;
      cool_q   <= '0;
      run_q    <= 1'b0;
      speed_q  <= SPEED_MIN;
      jump_q   <= 1'b0;
      height_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      peak_q   <= peak_d;
      rise_q   <= rise_d;
      cool_q   <= cool_d;
      run_q    <= run_d;
      speed_q  <= speed_d;
      jump_q   <= jump_d;
      height_q <= height_d;
    end
  end

  assign bus.run         = run_q;
  assign bus.run_speed   = speed_q;
  assign bus.jump        = jump_q;
  assign bus.jump_height = height_q;
  assign bus.jstate      = state_q;

endmodule

// File: tb/tb_voice_action_ctrl.sv
// Bench for voice_action_ctrl: a table of samples with hand-derived expected
// outputs, checked through a scoreboard queue one cycle after each sample,
// plus a back-to-back sample sequence at the end.
module tb_voice_action_ctrl;
  localparam int NVEC = 57;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  voice_action_ctrl_if vif();

  voice_action_ctrl dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (vif)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        val;
    logic [7:0]  vol;
    logic        run;
    logic [15:0] spd;
    logic [15:0] spd_r;
    logic        jump;
    logic [15:0] ht;
    logic [1:0]  js;
  } vec_t;

  typedef struct {
    logic        run;
    logic [15:0] spd;
    logic        jump;
    logic [15:0] ht;
    logic [1:0]  js;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic rst, input logic en, input logic val,
                              input int vol, input logic run, input int spd,
                              input int spd_r, input logic jump, input int ht,
                              input int js);
    vec_t v;
    v.rst = rst; v.en = en; v.val = val; v.vol = 8'(vol);
    v.run = run; v.spd = 16'(spd); v.spd_r = 16'(spd_r);
    v.jump = jump; v.ht = 16'(ht); v.js = 2'(js);
    return v;
  endfunction

  function automatic exp_t mk_exp(input logic run, input int spd, input logic jump,
                                  input int ht, input int js);
    exp_t e;
    e.run = run; e.spd = 16'(spd); e.jump = jump; e.ht = 16'(ht); e.js = 2'(js);
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got output with no expectation", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " run"},    16'(vif.run),    16'(e.run));
      chk({tag, " speed"},  vif.run_speed,   e.spd);
      chk({tag, " jump"},   16'(vif.jump),   16'(e.jump));
      chk({tag, " height"}, vif.jump_height, e.ht);
      chk({tag, " jstate"}, 16'(vif.jstate), 16'(e.js));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  last_js;
    logic [15:0] last_ht;
    exp_t        e;

    //                 rst en val vol  run spd spdR jmp ht js
    vecs[0]  = mk(1, 0, 0,   0,  0, 2, 2, 0,  0, 0);
    vecs[1]  = mk(0, 1, 1,  20,  0, 2, 2, 0,  0, 0);
    vecs[2]  = mk(0, 1, 1,  31,  1, 2, 2, 0,  0, 0);
    vecs[3]  = mk(0, 1, 1,  28,  1, 2, 2, 0,  0, 0);
    vecs[4]  = mk(0, 1, 1,  24,  0, 2, 2, 0,  0, 0);
    vecs[5]  = mk(0, 1, 1,  31,  1, 2, 2, 0,  0, 0);
    vecs[6]  = mk(0, 1, 1,  50,  1, 3, 3, 0,  0, 0);
    vecs[7]  = mk(0, 1, 1,  65,  1, 4, 4, 0,  0, 0);
    vecs[8]  = mk(0, 1, 1,  44,  1, 2, 3, 0,  0, 0);
    vecs[9]  = mk(0, 1, 1,  90,  1, 4, 4, 0,  0, 1);
    vecs[10] = mk(0, 1, 1, 120,  1, 4, 4, 0,  0, 1);
    vecs[11] = mk(0, 1, 1, 100,  1, 4, 4, 0,  0, 1);
    vecs[12] = mk(0, 1, 1,  40,  1, 2, 3, 1, 18, 2);
    vecs[13] = mk(0, 1, 1,  24,  0, 2, 2, 0, 18, 2);
    vecs[14] = mk(0, 1, 1,  10,  0, 2, 2, 0, 18, 2);
    vecs[15] = mk(0, 1, 1,  10,  0, 2, 2, 0, 18, 2);
    vecs[16] = mk(0, 1, 1,  10,  0, 2, 2, 0, 18, 0);
    vecs[17] = mk(0, 1, 1, 200,  1, 4, 3, 0, 18, 1);
    vecs[18] = mk(0, 1, 1, 200,  1, 4, 4, 0, 18, 1);
    vecs[19] = mk(0, 1, 1, 200,  1, 4, 4, 0, 18, 1);
    vecs[20] = mk(0, 1, 1, 200,  1, 4, 4, 0, 18, 1);
    vecs[21] = mk(0, 1, 1, 200,  1, 4, 4, 0, 18, 1);
    vecs[22] = mk(0, 1, 1, 200,  1, 4, 4, 1, 38, 2);
    vecs[23] = mk(0, 1, 1, 200,  1, 4, 4, 0, 38, 2);
    vecs[24] = mk(0, 1, 1, 150,  1, 4, 4, 0, 38, 2);
    vecs[25] = mk(0, 1, 1, 150,  1, 4, 4, 0, 38, 2);
    vecs[26] = mk(0, 1, 1, 150,  1, 4, 4, 0, 38, 0);
    vecs[27] = mk(0, 1, 1, 150,  1, 4, 4, 0, 38, 1);
    vecs[28] = mk(0, 1, 1,  60,  1, 4, 4, 1, 25, 2);
    vecs[29] = mk(0, 1, 1,  59,  1, 3, 3, 0, 25, 2);
    vecs[30] = mk(0, 1, 1,  59,  1, 3, 3, 0, 25, 2);
    vecs[31] = mk(0, 1, 1,  59,  1, 3, 3, 0, 25, 2);
    vecs[32] = mk(0, 1, 1,  59,  1, 3, 3, 0, 25, 0);
    vecs[33] = mk(0, 1, 1, 110,  1, 4, 4, 0, 25, 1);
    vecs[34] = mk(0, 0, 0,   0,  0, 2, 2, 0, 25, 0);
    vecs[35] = mk(0, 0, 1, 200,  0, 2, 2, 0, 25, 0);
    vecs[36] = mk(0, 0, 0,   0,  0, 2, 2, 0, 25, 0);
    vecs[37] = mk(0, 1, 1,  50,  1, 3, 3, 0, 25, 0);
    vecs[38] = mk(0, 1, 1,  90,  1, 4, 4, 0, 25, 1);
    vecs[39] = mk(0, 1, 1, 100,  1, 4, 4, 0, 25, 1);
    vecs[40] = mk(0, 1, 1,   0,  0, 2, 2, 1, 13, 2);
    vecs[41] = mk(0, 1, 1,   0,  0, 2, 2, 0, 13, 2);
    vecs[42] = mk(1, 1, 1, 200,  0, 2, 2, 0,  0, 0);
    vecs[43] = mk(0, 1, 1,  85,  1, 4, 3, 0,  0, 1);
    vecs[44] = mk(0, 1, 1,  79,  1, 4, 4, 1,  9, 2);
    vecs[45] = mk(0, 1, 1,  80,  1, 4, 4, 0,  9, 2);
    vecs[46] = mk(0, 1, 1,  80,  1, 4, 4, 0,  9, 2);
    vecs[47] = mk(0, 1, 1,  80,  1, 4, 4, 0,  9, 2);
    vecs[48] = mk(0, 1, 1,  80,  1, 4, 4, 0,  9, 0);
    vecs[49] = mk(0, 1, 1, 255,  1, 4, 4, 0,  9, 1);
    vecs[50] = mk(0, 1, 1,  80,  1, 4, 4, 0,  9, 1);
    vecs[51] = mk(0, 1, 1,  79,  1, 4, 4, 1, 51, 2);
    vecs[52] = mk(0, 1, 1,  25,  1, 2, 3, 0, 51, 2);
    vecs[53] = mk(0, 1, 1,  24,  0, 2, 2, 0, 51, 2);
    vecs[54] = mk(0, 1, 1,  30,  1, 2, 2, 0, 51, 2);
    vecs[55] = mk(0, 1, 1,  45,  1, 3, 3, 0, 51, 0);
    vecs[56] = mk(0, 1, 1,  60,  1, 4, 4, 0, 51, 0);

    vif.enable    = 1'b0;
    vif.vol_valid = 1'b0;
    vif.vol       = 8'd0;
    last_js       = 2'd0;
    last_ht       = 16'd0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge i_clk);
      if (i > 0) begin
        // Cycle without a sample: pulse gone, FSM and height unchanged.
        chk($sformatf("row%0d idle jump", i),   16'(vif.jump),   16'd0);
        chk($sformatf("row%0d idle jstate", i), 16'(vif.jstate), 16'(last_js));
        chk($sformatf("row%0d idle height", i), vif.jump_height, last_ht);
      end
      i_rst         = vecs[i].rst;
      vif.enable    = vecs[i].en;
      vif.vol_valid = vecs[i].val;
      vif.vol       = vecs[i].vol;
`ifdef SPEED_RAMP_EN
      exp_q.push_back(mk_exp(vecs[i].run, int'(vecs[i].spd_r), vecs[i].jump,
                             int'(vecs[i].ht), int'(vecs[i].js)));
`else
      exp_q.push_back(mk_exp(vecs[i].run, int'(vecs[i].spd), vecs[i].jump,
                             int'(vecs[i].ht), int'(vecs[i].js)));
`endif
      @(negedge i_clk);
      vif.vol_valid = 1'b0;
      i_rst         = 1'b0;
      sb_compare($sformatf("row%0d", i));
      last_js = vecs[i].js;
      last_ht = vecs[i].ht;
    end

    // Back-to-back samples: 90, 95, 10 on consecutive cycles.
    @(negedge i_clk);
    vif.enable    = 1'b1;
    vif.vol_valid = 1'b1;
    vif.vol       = 8'd90;
    exp_q.push_back(mk_exp(1'b1, 4, 1'b0, 51, 1));
    @(negedge i_clk);
    sb_compare("b2b s1");
    vif.vol = 8'd95;
    exp_q.push_back(mk_exp(1'b1, 4, 1'b0, 51, 1));
    @(negedge i_clk);
    sb_compare("b2b s2");
    vif.vol = 8'd10;
    e = mk_exp(1'b0, 2, 1'b1, 11, 2);
    exp_q.push_back(e);
    @(negedge i_clk);
    sb_compare("b2b s3");
    vif.vol_valid = 1'b0;
    @(negedge i_clk);
    chk("b2b pulse end",   16'(vif.jump),   16'd0);
    chk("b2b cool hold",   16'(vif.jstate), 16'd2);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard drain: %0d left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
